// File: rtl/board_io_pkg.sv
// Shared board I/O constants for the input conditioning path.
// Holds channel counts, debounce lengths and the counter width helper.
package board_io_pkg;

    // Slide switch and push-button counts on the board.
    localparam int unsigned N_SW  = 10;
    localparam int unsigned N_KEY = 2;

    // 10 ms at 50 MHz on hardware; short value for simulation.
    localparam int unsigned DEB_CYCLES_HW  = 500000;
    localparam int unsigned DEB_CYCLES_SIM = 4;

    // Width of a counter that must reach n-1.
    // Never returns less than 1 so the counter always has a bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = (n > 1) ? $clog2(n) : 1;
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One conditioning channel: 2-flop synchronizer, stability counter,
// stable level register and registered rise/fall pulses.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   din   - raw asynchronous input (active-high)
//   level - debounced level
//   rise  - one-cycle pulse when level goes 0 -> 1
//   fall  - one-cycle pulse when level goes 1 -> 0
module debounce_bit
    import board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_SIM
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q;
    logic          s1_d;
    logic          s2_q;
    logic          s2_d;
    logic          stb_q;
    logic          stb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          rise_q;
    logic          rise_d;
    logic          fall_q;
    logic          fall_d;
    logic          upd;

    always_comb begin
        s1_d  = din;
        s2_d  = s1_q;
        stb_d = stb_q;
        cnt_d = '0;
        upd   = 1'b0;
        // Any sample agreeing with the stable level clears the run,
        // so only an unbroken disagreement run reaches CNT_MAX.
        if (s2_q != stb_q) begin
            if (cnt_q == CNT_MAX) begin
                stb_d = s2_q;
                upd   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = upd & stb_d;
        fall_d = upd & ~stb_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            stb_q  <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            stb_q  <= stb_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = stb_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces board switches and active-low keys,
// giving clean levels plus key press/release pulses.
//
// Ports:
//   MAX10_CLK1_50 - system clock
//   reset         - asynchronous active-high reset
//   SW            - raw switch pins
//   KEY           - raw key pins, active-low
//   sw_level      - debounced switch levels
//   key_level     - debounced key state, 1 = pressed
//   key_press     - one-cycle pulse on press
//   key_release   - one-cycle pulse on release
module input_conditioner
    import board_io_pkg::*;
#(
    parameter int unsigned N_SW            = board_io_pkg::N_SW,
    parameter int unsigned N_KEY           = board_io_pkg::N_KEY,
    parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_HW
) (
    input  logic             MAX10_CLK1_50,
    input  logic             reset,
    input  logic [N_SW-1:0]  SW,
    input  logic [N_KEY-1:0] KEY,
    output logic [N_SW-1:0]  sw_level,
    output logic [N_KEY-1:0] key_level,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_release
);

    // Keys are inverted up front so every channel is active-high.
    logic [N_KEY-1:0] key_act;
    logic [N_SW-1:0]  sw_rise_unused;
    logic [N_SW-1:0]  sw_fall_unused;

    assign key_act = ~KEY;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (MAX10_CLK1_50),
            .rst  (reset),
            .din  (SW[i]),
            .level(sw_level[i]),
            .rise (sw_rise_unused[i]),
            .fall (sw_fall_unused[i])
        );
    end

    for (genvar k = 0; k < N_KEY; k++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (MAX10_CLK1_50),
            .rst  (reset),
            .din  (key_act[k]),
            .level(key_level[k]),
            .rise (key_press[k]),
            .fall (key_release[k])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Randomized and directed bench for input_conditioner.
// Reference: level follows the pin once it has disagreed for D edges.
module tb_input_conditioner;

    localparam int D  = 4;
    localparam int NC = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] SW;
    logic [1:0] KEY;
    logic [9:0] sw_level;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;

    int checks = 0;
    int errors = 0;

    // Reference state: pin samples seen at recent edges, accepted level,
    // length of the current disagreement run, expected pulses.
    logic [NC-1:0] hist[$];
    logic [NC-1:0] lvl;
    logic [NC-1:0] pr;
    logic [NC-1:0] pf;
    int            run[NC];

    always #5 clk = ~clk;

    input_conditioner #(
        .N_SW(10),
        .N_KEY(2),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .MAX10_CLK1_50(clk),
        .reset(reset),
        .SW(SW),
        .KEY(KEY),
        .sw_level(sw_level),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release)
    );

    task automatic model_clear();
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
        lvl = '0;
        pr  = '0;
        pf  = '0;
        for (int c = 0; c < NC; c++) run[c] = 0;
    endtask

    // Input reaching the debouncer two edges after being sampled.
    task automatic model_edge();
        logic [NC-1:0] pin;
        logic [NC-1:0] seen;
        pin = {~KEY, SW};
        if (reset) begin
            model_clear();
        end else begin
            seen = hist.pop_front();
            hist.push_back(pin);
            pr = '0;
            pf = '0;
            for (int c = 0; c < NC; c++) begin
                if (seen[c] !== lvl[c]) begin
                    run[c]++;
                    if (run[c] >= D) begin
                        lvl[c] = seen[c];
                        pr[c]  = seen[c];
                        pf[c]  = ~seen[c];
                        run[c] = 0;
                    end
                end else begin
                    run[c] = 0;
                end
            end
        end
    endtask

    task automatic compare(input string tag);
        logic [9:0] e_sw;
        logic [1:0] e_kl;
        logic [1:0] e_kp;
        logic [1:0] e_kr;
        e_sw = lvl[9:0];
        e_kl = lvl[11:10];
        e_kp = pr[11:10];
        e_kr = pf[11:10];
        checks++;
        assert (sw_level === e_sw) else begin
            errors++;
            $error("FAIL %s sw_level got %h exp %h t=%0t",
                   tag, sw_level, e_sw, $time);
        end
        checks++;
        assert (key_level === e_kl) else begin
            errors++;
            $error("FAIL %s key_level got %b exp %b t=%0t",
                   tag, key_level, e_kl, $time);
        end
        checks++;
        assert (key_press === e_kp) else begin
            errors++;
            $error("FAIL %s key_press got %b exp %b t=%0t",
                   tag, key_press, e_kp, $time);
        end
        checks++;
        assert (key_release === e_kr) else begin
            errors++;
            $error("FAIL %s key_release got %b exp %b t=%0t",
                   tag, key_release, e_kr, $time);
        end
    endtask

    task automatic tick(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare(tag);
        end
    endtask

    initial begin
        int hold;
        model_clear();

        // Reset with switches up and keys pressed.
        reset = 1'b1;
        SW    = 10'h3FF;
        KEY   = 2'b00;
        #1;
        checks++;
        assert (sw_level === 10'h000 && key_level === 2'b00 &&
                key_press === 2'b00 && key_release === 2'b00) else begin
            errors++;
            $error("FAIL reset_outs got %h/%b/%b/%b exp 0",
                   sw_level, key_level, key_press, key_release);
        end
        tick("in_reset", 3);
        reset = 1'b0;
        tick("post_reset", 5);
        // Edge 6 after release: levels up, one press pulse each key.
        tick("post_reset_e6", 1);
        checks++;
        assert (key_press === 2'b11 && sw_level === 10'h3FF) else begin
            errors++;
            $error("FAIL e6_press got %b/%h exp 11/3ff",
                   key_press, sw_level);
        end
        tick("post_reset_hold", 4);

        // Release keys, clear switches, let it settle.
        KEY = 2'b11;
        SW  = 10'h000;
        tick("settle", 10);

        // Clean switch change.
        SW[2:1] = 2'b11;
        tick("sw_change", 12);

        // Bounce on KEY[1].
        KEY[1] = 1'b0; tick("bounce", 3);
        KEY[1] = 1'b1; tick("bounce", 1);
        KEY[1] = 1'b0; tick("bounce", 3);
        tick("bounce_hold", 10);

        // Press and release KEY[0].
        KEY[0] = 1'b0; tick("k0_press", 10);
        KEY[0] = 1'b1; tick("k0_release", 10);

        // Simultaneous switch and key events.
        KEY = 2'b11;
        SW  = 10'h000;
        tick("settle2", 10);
        SW[9:4] = 6'b000010;
        KEY[0]  = 1'b0;
        tick("simul", 5);
        tick("simul_e6", 1);
        checks++;
        assert (sw_level[5] === 1'b1 && key_press === 2'b01) else begin
            errors++;
            $error("FAIL simul_e6 got sw5=%b press=%b exp 1/01",
                   sw_level[5], key_press);
        end
        tick("simul_hold", 4);

        // Reset in the middle of a KEY[1] debounce.
        KEY = 2'b11;
        tick("settle3", 10);
        KEY[1] = 1'b0;
        tick("mid_rst", 4);
        reset = 1'b1;
        tick("mid_rst_on", 2);
        reset = 1'b0;
        tick("mid_rst_off", 10);

        // Randomized pins with random hold times and rare resets.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                tick("rand_rst", $urandom_range(1, 2));
                reset = 1'b0;
            end
            if ($urandom_range(0, 1) == 0) SW  = 10'($urandom);
            else SW[$urandom_range(0, 9)] = ~SW[$urandom_range(0, 9)];
            if ($urandom_range(0, 2) != 0) KEY = 2'($urandom);
            hold = ($urandom_range(0, 2) == 0) ?
                   $urandom_range(1, 4) : $urandom_range(5, 9);
            tick("rand", hold);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
